// File: rtl/sram_port_arb_pkg.sv
// Shared owner codes, queue depth and transfer-size encodings for the SRAM port arbiter.
package sram_port_arb_pkg;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int         ARB_DEPTH = 2;
  localparam logic [1:0] ARB_FULL  = 2'(ARB_DEPTH);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_t;
endpackage

// File: rtl/sram_port_arb_owner_fifo.sv
// Two-entry in-order queue of request owners, one bit per outstanding transaction.
module owner_fifo
  import sram_port_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic       din,
  output logic       dout,
  output logic [1:0] count
);

  logic [ARB_DEPTH-1:0] entry;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign push_ok = push & (count != ARB_FULL);
  assign pop_ok  = pop & (count != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Owner bits are payload only; pointers and count carry all the state.
  always_ff @(posedge clk) begin
    if (push_ok) entry[wr_ptr] <= din;
  end

  assign dout = entry[rd_ptr];

endmodule

// File: rtl/sram_port_arb.sv
// Merges fetch and load/store request ports onto one SRAM-like port, up to two outstanding.
module sram_port_arb
  import sram_port_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       lock_own;
  logic       lock_own_nxt;
  logic       grant;
  logic       head;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // A pending unaccepted request pins the grant so mem_* stays stable until accepted.
  assign grant   = (state == ARB_LOCKED) ? lock_own : (data_req ? OWN_DATA : OWN_INST);
  assign mem_req = resetn & (inst_req | data_req) & (count != ARB_FULL);
  assign push    = mem_req & mem_addr_ok;
  assign pop     = resetn & mem_data_ok & (count != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ARB_FREE;
      lock_own <= OWN_INST;
    end else begin
      state    <= state_nxt;
      lock_own <= lock_own_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_own_nxt = lock_own;
    case (state)
      ARB_FREE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt    = ARB_LOCKED;
          lock_own_nxt = grant;
        end
      end
      ARB_LOCKED: begin
        if (!mem_req || mem_addr_ok) state_nxt = ARB_FREE;
      end
      default: state_nxt = ARB_FREE;
    endcase
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = inst_size;
    mem_wstrb = 4'b0000;
    mem_addr  = inst_addr;
    mem_wdata = 32'h0;
    if (grant == OWN_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = push & (grant == OWN_INST);
  assign data_addr_ok = push & (grant == OWN_DATA);
  assign inst_data_ok = pop & (head == OWN_INST);
  assign data_data_ok = pop & (head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  owner_fifo u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (grant),
    .dout   (head),
    .count  (count)
  );

endmodule

// File: tb/tb_sram_port_arb.sv
// Scoreboard bench for sram_port_arb: expected owners/data queued on accept, checked on response.
module tb_sram_port_arb;
  import sram_port_arb_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic        own;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_port_arb dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic idle();
    inst_req = 1'b0; inst_size = SIZE_WORD; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req);
    end
    checks++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshakes: got %b expected 0000",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    @(negedge clk);
    idle();
    resetn = 1'b1;
    inst_req = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL post_reset_mem_req: got %b expected 1", mem_req);
    end
    apply_reset();
  endtask

  task automatic test_priority();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_size = SIZE_WORD;
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_HALF; data_wstrb = 4'b0011;
    data_addr = 32'h0000_0100; data_wdata = 32'hdead_beef; mem_addr_ok = 1'b1;
    #1;
    checks++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL prio_addr_ok: got data/inst %b expected 10", {data_addr_ok, inst_addr_ok});
    end
    checks++;
    if (mem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL prio_mem_addr: got %h expected 00000100", mem_addr);
    end
    checks++;
    if ({mem_wr, mem_size, mem_wstrb, mem_wdata} !== {1'b1, SIZE_HALF, 4'b0011, 32'hdead_beef}) begin
      errors++;
      $display("FAIL prio_store_fields: got wr=%b size=%0d wstrb=%b wdata=%h expected 1/1/0011/deadbeef",
               mem_wr, mem_size, mem_wstrb, mem_wdata);
    end
    @(negedge clk);
    data_req = 1'b0;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1c00_0000) begin
      errors++;
      $display("FAIL inst_grant: got inst/data ok %b addr %h expected 10 1c000000",
               {inst_addr_ok, data_addr_ok}, mem_addr);
    end
    checks++;
    if ({mem_wr, mem_wstrb, mem_wdata, mem_size} !== {1'b0, 4'b0000, 32'h0, SIZE_WORD}) begin
      errors++;
      $display("FAIL inst_fields: got wr=%b wstrb=%b wdata=%h size=%0d expected 0/0000/0/2",
               mem_wr, mem_wstrb, mem_wdata, mem_size);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL full_block: got req/ok %b expected 00", {mem_req, inst_addr_ok});
    end
    apply_reset();
  endtask

  task automatic test_lock();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h1c00_0040; data_req = 1'b0; mem_addr_ok = 1'b0;
      #1;
      checks++;
      if ({mem_req, inst_addr_ok} !== 2'b10 || mem_addr !== 32'h1c00_0040) begin
        errors++;
        $display("FAIL lock_wait_%0d: got req/ok %b addr %h expected 10 1c000040",
                 c, {mem_req, inst_addr_ok}, mem_addr);
      end
    end
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf; data_addr = 32'h0000_0300;
    data_wdata = 32'h1234_5678; mem_addr_ok = 1'b1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1c00_0040 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL lock_hold: got inst/data ok %b addr %h wr %b expected 10 1c000040 0",
               {inst_addr_ok, data_addr_ok}, mem_addr, mem_wr);
    end
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01 || mem_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL lock_release: got inst/data ok %b addr %h expected 01 00000300",
               {inst_addr_ok, data_addr_ok}, mem_addr);
    end
    apply_reset();
  endtask

  task automatic test_in_order();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    #1;
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL order_inst_accept: got %b expected 1", inst_addr_ok);
    end
    sb.push_back('{own: OWN_INST, rdata: 32'h0000_000A});
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL order_data_accept: got %b expected 1", data_addr_ok);
    end
    sb.push_back('{own: OWN_DATA, rdata: 32'h0000_000B});
  endtask

  task automatic test_full();
    @(negedge clk);
    idle();
    inst_req = 1'b1; inst_addr = 32'h1c00_0080; mem_addr_ok = 1'b1;
    sb.push_back('{own: OWN_INST, rdata: 32'h0000_00C1});
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0180;
    sb.push_back('{own: OWN_DATA, rdata: 32'h0000_00C2});
    @(negedge clk);
    data_req = 1'b0; inst_req = 1'b1;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL full_no_req: got req/ok %b expected 00", {mem_req, inst_addr_ok});
    end
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = sb[0].rdata;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b001) begin
      errors++;
      $display("FAIL full_pop_same_cycle: got req/addr_ok/data_ok %b expected 001",
               {mem_req, inst_addr_ok, inst_data_ok});
    end
    void'(sb.pop_front());
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok} !== 2'b11) begin
      errors++; $display("FAIL full_release: got req/ok %b expected 11", {mem_req, inst_addr_ok});
    end
    sb.push_back('{own: OWN_INST, rdata: 32'h0000_00C3});
  endtask

  task automatic test_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      idle();
      mem_data_ok = 1'b1; mem_rdata = e.rdata;
      #1;
      checks++;
      if ({inst_data_ok, data_data_ok} !== {e.own == OWN_INST, e.own == OWN_DATA}) begin
        errors++;
        $display("FAIL drain_owner: got inst/data ok %b expected %b",
                 {inst_data_ok, data_data_ok}, {e.own == OWN_INST, e.own == OWN_DATA});
      end
      checks++;
      if ((e.own == OWN_INST ? inst_rdata : data_rdata) !== e.rdata) begin
        errors++;
        $display("FAIL drain_rdata: got %h expected %h",
                 (e.own == OWN_INST ? inst_rdata : data_rdata), e.rdata);
      end
    end
    @(negedge clk);
    idle();
    mem_data_ok = 1'b1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL drain_empty: got %b expected 00", {inst_data_ok, data_data_ok});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    logic own;
    exp_t e;
    @(negedge clk);
    idle();
    data_req = 1'b1; data_addr = 32'h0000_0400; mem_addr_ok = 1'b1;
    sb.push_back('{own: OWN_DATA, rdata: 32'h3000_0000});
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      own = (i % 3 == 0) ? OWN_DATA : OWN_INST;
      inst_req = (own == OWN_INST); data_req = (own == OWN_DATA);
      inst_addr = 32'h1c00_0000 + 32'(i * 4); data_addr = 32'h0000_0400 + 32'(i * 4);
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      e = sb.pop_front();
      mem_rdata = e.rdata;
      #1;
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== {own == OWN_INST, own == OWN_DATA}) begin
        errors++;
        $display("FAIL b2b_accept_%0d: got inst/data ok %b expected %b",
                 i, {inst_addr_ok, data_addr_ok}, {own == OWN_INST, own == OWN_DATA});
      end
      checks++;
      if ({inst_data_ok, data_data_ok} !== {e.own == OWN_INST, e.own == OWN_DATA}) begin
        errors++;
        $display("FAIL b2b_resp_%0d: got inst/data ok %b expected %b",
                 i, {inst_data_ok, data_data_ok}, {e.own == OWN_INST, e.own == OWN_DATA});
      end
      sb.push_back('{own: own, rdata: 32'h3000_0000 + 32'(i)});
    end
  endtask

  task automatic test_spurious_and_reset();
    @(negedge clk);
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_bad0;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL spurious_idle: got %b expected 00", {inst_data_ok, data_data_ok});
    end
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h0000_0200; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    checks++;
    if ({data_addr_ok, data_data_ok} !== 2'b10) begin
      errors++; $display("FAIL spurious_with_push: got addr/data ok %b expected 10", {data_addr_ok, data_data_ok});
    end
    sb.push_back('{own: OWN_DATA, rdata: 32'h0000_5555});
    test_drain();
    @(negedge clk);
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL two_outstanding: got mem_req %b expected 0", mem_req);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({mem_req, inst_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL async_reset: got req/ok %b expected 00", {mem_req, inst_addr_ok});
    end
    @(negedge clk);
    resetn = 1'b1; mem_addr_ok = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_cleared_count: got mem_req %b expected 1", mem_req);
    end
    inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_dead;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL stale_response: got %b expected 00", {inst_data_ok, data_data_ok});
    end
    sb.delete();
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_priority();
    test_lock();
    test_in_order();
    test_drain();
    apply_reset();
    test_full();
    test_drain();
    apply_reset();
    test_back_to_back();
    test_drain();
    apply_reset();
    test_spurious_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 resetn  in  1  reset; asynchronous assertion, active-low.
REQ-004 inst_req  in  1  fetch-side read request.
REQ-005 inst_size  in  2  fetch transfer size (0=byte, 1=half, 2=word).
REQ-006 inst_addr  in  32  fetch address.
REQ-007 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-008 inst_data_ok  out  1  fetch read data valid this cycle.
REQ-009 inst_rdata  out  32  fetch read data.
REQ-010 data_req  in  1  load/store request.
REQ-011 data_wr  in  1  1 = store.
REQ-012 data_size  in  2  load/store size.
REQ-013 data_wstrb  in  4  store byte enables.
REQ-014 data_addr  in  32  load/store address.
REQ-015 data_wdata  in  32  store data.
REQ-016 data_addr_ok  out  1  load/store request accepted this cycle.
REQ-017 data_data_ok  out  1  load data valid or store complete this cycle.
REQ-018 data_rdata  out  32  load data.
REQ-019 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared downstream request.
REQ-020 mem_addr_ok  in  1  downstream accepted request.
REQ-021 mem_data_ok  in  1  downstream response.
REQ-022 mem_rdata  in  32  downstream read data.

Function
REQ-023 Outstanding depth SHALL be 2.
REQ-024 Outstanding count SHALL range 0..2.
REQ-025 The block SHALL assert mem_req = (inst_req|data_req) & (count<2).
REQ-026 When arbitration is free, data SHALL win over inst.
REQ-027 Once mem_req is high with mem_addr_ok low, the grant SHALL lock to the current winner until mem_addr_ok, even if the other requester rises.
REQ-028 mem_* fields SHALL mux from the granted requester.
REQ-029 An inst grant SHALL drive mem_wr=0, mem_wstrb=0, mem_wdata=0.
REQ-030 x_addr_ok = mem_req & mem_addr_ok & (grant==x); it SHALL be combinational, with at most one asserted per cycle.
REQ-031 On mem_req&mem_addr_ok the granted owner SHALL be pushed into an in-order owner queue.
REQ-032 On mem_data_ok with count>0, the head SHALL be popped.
REQ-033 On a mem_data_ok pop, x_data_ok SHALL assert for head owner x.
REQ-034 inst_rdata and data_rdata SHALL both equal mem_rdata.
REQ-035 Simultaneous push and pop SHALL leave count unchanged; the popped entry is the older one.
REQ-036 mem_data_ok with count==0 SHALL be ignored: no x_data_ok, no state change; this includes a same-cycle push.
REQ-037 When count==2: mem_req=0 and both addr_ok=0 until a pop; a pop in that cycle does not release the request the same cycle.
REQ-038 Queue pointers SHALL wrap modulo 2.
REQ-039 Latency: the arbiter SHALL add zero cycles on request and response paths.

Reset
REQ-040 While resetn=0: count=0, pointers=0, grant lock cleared, mem_req=0, all addr_ok/data_ok=0.
REQ-041 Reset mid-transaction SHALL discard outstanding owners; responses arriving after release are ignored per REQ-036.

Structure
REQ-042 Shared package SHALL hold OWN_INST=1'b0, OWN_DATA=1'b1, ARB_DEPTH=2, and the size encodings.
REQ-043 The owner queue SHALL be sub-module owner_fifo (depth 2, 1-bit, push/pop/count).

Verification
REQ-044 Both req=1 at count 0, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr.
REQ-045 inst req with mem_addr_ok=0 for 3 cycles, then data_req rises -> grant stays inst; inst_addr_ok on cycle 4.
REQ-046 Accept inst@0x1c000000 then data load@0x100 -> mem_data_ok with rdata 0xA then 0xB gives inst_data_ok/0xA, then data_data_ok/0xB.
REQ-047 Two accepted, no response -> mem_req=0; mem_data_ok and new req same cycle -> request accepted next cycle only.
REQ-048 Spurious mem_data_ok at count 0 -> no data_ok outputs; resetn pulse with count=2 -> count=0, mem_req=0 asynchronously.
